// File: rtl/cam_pkg.sv
// Shared constants and helpers for param_cam: op-priority encoding and index-width derivation.
package cam_pkg;

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_FLUSH  = 3'd1;
    localparam logic [2:0] OP_SEARCH = 3'd2;
    localparam logic [2:0] OP_WRITE  = 3'd3;
    localparam logic [2:0] OP_INV    = 3'd4;

    function automatic int cam_addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/param_cam_if.sv
// Request/response bundle for param_cam; wmask exists only when CAM_TERNARY_EN is defined.
interface param_cam_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    import cam_pkg::*;

    localparam int ADDR_W = cam_addr_w(DEPTH);

    logic              ren;
    logic              wen;
    logic              alloc;
    logic              inv;
    logic              flush;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
`ifdef CAM_TERNARY_EN
    logic [DATA_W-1:0] wmask;
`endif
    logic [ADDR_W-1:0] dout;
    logic              hit;
    logic              multi_hit;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_err;
    logic [ADDR_W:0]   count;
    logic              full;

`ifdef CAM_TERNARY_EN
    modport master (output ren, wen, alloc, inv, flush, din, addr, wmask,
                    input  dout, hit, multi_hit, wr_addr, wr_err, count, full);
    modport slave  (input  ren, wen, alloc, inv, flush, din, addr, wmask,
                    output dout, hit, multi_hit, wr_addr, wr_err, count, full);
`else
    modport master (output ren, wen, alloc, inv, flush, din, addr,
                    input  dout, hit, multi_hit, wr_addr, wr_err, count, full);
    modport slave  (input  ren, wen, alloc, inv, flush, din, addr,
                    output dout, hit, multi_hit, wr_addr, wr_err, count, full);
`endif

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit encoder over an N-bit vector, with any-set and two-or-more-set flags.
module cam_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[W'(i)] && !found) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
        any   = |vec;
        // clearing the lowest set bit leaves something only if two or more were set
        multi = |(vec & (vec - N'(1)));
    end

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM with valid bits, alloc/explicit writes, invalidate, flush and one-cycle search.
// Define CAM_TERNARY_EN to store a per-entry don't-care mask written from wmask.
module param_cam
    import cam_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic         clk,
    input  logic         rst,
    param_cam_if.slave   bus
);

    localparam int ADDR_W = cam_addr_w(DEPTH);
    localparam int CW     = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef CAM_TERNARY_EN
    logic [DATA_W-1:0] mask_mem [DEPTH];
`endif
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  match;
    logic [2:0]        op;

    logic [ADDR_W-1:0] match_idx;
    logic              match_any;
    logic              match_multi;
    logic [ADDR_W-1:0] free_idx;
    logic              free_any;
    logic              free_multi;

    logic [ADDR_W-1:0] tgt;
    logic              wr_ok;

    always_comb begin
        op = OP_NONE;
        if (bus.flush)    op = OP_FLUSH;
        else if (bus.ren) op = OP_SEARCH;
        else if (bus.wen) op = OP_WRITE;
        else if (bus.inv) op = OP_INV;
    end

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef CAM_TERNARY_EN
            match[ADDR_W'(i)] = valid[ADDR_W'(i)] &&
                (((mem[ADDR_W'(i)] ^ bus.din) & ~mask_mem[ADDR_W'(i)]) == '0);
`else
            match[ADDR_W'(i)] = valid[ADDR_W'(i)] && (mem[ADDR_W'(i)] == bus.din);
`endif
        end
    end

    cam_prio_enc #(.N(DEPTH), .W(ADDR_W)) u_match_enc (
        .vec   (match),
        .idx   (match_idx),
        .any   (match_any),
        .multi (match_multi)
    );

    cam_prio_enc #(.N(DEPTH), .W(ADDR_W)) u_free_enc (
        .vec   (~valid),
        .idx   (free_idx),
        .any   (free_any),
        .multi (free_multi)
    );

    always_comb begin
        tgt   = bus.alloc ? free_idx : bus.addr;
        wr_ok = !bus.alloc || free_any;
    end

    // data/mask storage is deliberately never reset; valid gates every match
    always_ff @(posedge clk) begin
        if (!rst && op == OP_WRITE && wr_ok) begin
            mem[tgt] <= bus.din;
`ifdef CAM_TERNARY_EN
            mask_mem[tgt] <= bus.wmask;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            bus.count     <= '0;
            bus.dout      <= '0;
            bus.hit       <= 1'b0;
            bus.multi_hit <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_err    <= 1'b0;
        end else begin
            bus.dout      <= '0;
            bus.hit       <= 1'b0;
            bus.multi_hit <= 1'b0;
            bus.wr_err    <= 1'b0;
            case (op)
                OP_FLUSH: begin
                    valid     <= '0;
                    bus.count <= '0;
                end
                OP_SEARCH: begin
                    bus.dout      <= match_idx;
                    bus.hit       <= match_any;
                    bus.multi_hit <= match_multi;
                end
                OP_WRITE: begin
                    if (!wr_ok) begin
                        bus.wr_err <= 1'b1;
                    end else begin
                        valid[tgt]  <= 1'b1;
                        bus.wr_addr <= tgt;
                        if (!valid[tgt]) bus.count <= bus.count + CW'(1);
                    end
                end
                OP_INV: begin
                    if (valid[bus.addr]) begin
                        valid[bus.addr] <= 1'b0;
                        bus.count       <= bus.count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.full = (bus.count == CW'(DEPTH));

    // a single free slot must coincide with a count one short of full
    assert property (@(posedge clk) disable iff (rst)
        (free_any && !free_multi) |-> (bus.count == CW'(DEPTH - 1)));

endmodule

// File: tb/tb_param_cam.sv
// Directed plus randomized bench for param_cam against an array-based reference model.
module tb_param_cam;

`ifdef CAM_TERNARY_EN
    localparam bit TERN = 1'b1;
`else
    localparam bit TERN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    param_cam_if #(.DATA_W(8), .DEPTH(16)) bus ();

    param_cam #(.DATA_W(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] md [16];
    logic [7:0] mm [16];
    bit         mv [16];
    int e_dout, e_hit, e_multi, e_wr_addr, e_err, e_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".dout"},      32'(bus.dout),      32'(e_dout));
        chk({ctx, ".hit"},       32'(bus.hit),       32'(e_hit));
        chk({ctx, ".multi_hit"}, 32'(bus.multi_hit), 32'(e_multi));
        chk({ctx, ".wr_addr"},   32'(bus.wr_addr),   32'(e_wr_addr));
        chk({ctx, ".wr_err"},    32'(bus.wr_err),    32'(e_err));
        chk({ctx, ".count"},     32'(bus.count),     32'(e_count));
        chk({ctx, ".full"},      32'(bus.full),      32'(e_count == 16));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        e_dout = 0; e_hit = 0; e_multi = 0; e_wr_addr = 0; e_err = 0; e_count = 0;
    endfunction

    function automatic void model_apply(input bit r, w, a, iv, f,
                                        input logic [7:0] d, input int ad, input logic [7:0] wm);
        int n, t;
        e_dout = 0; e_hit = 0; e_multi = 0; e_err = 0;
        if (f) begin
            for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        end else if (r) begin
            n = 0;
            for (int i = 0; i < 16; i++)
                if (mv[i] && (((md[i] ^ d) & ~mm[i]) == 8'h00)) begin
                    if (n == 0) e_dout = i;
                    n++;
                end
            e_hit   = (n > 0) ? 1 : 0;
            e_multi = (n > 1) ? 1 : 0;
        end else if (w) begin
            t = -1;
            if (a) begin
                for (int i = 15; i >= 0; i--) if (!mv[i]) t = i;
            end else begin
                t = ad;
            end
            if (t < 0) e_err = 1;
            else begin
                md[t] = d;
                mm[t] = TERN ? wm : 8'h00;
                mv[t] = 1'b1;
                e_wr_addr = t;
            end
        end else if (iv) begin
            mv[ad] = 1'b0;
        end
        e_count = 0;
        for (int i = 0; i < 16; i++) e_count += int'(mv[i]);
    endfunction

    task automatic drive(input bit r, w, a, iv, f, input logic [7:0] d,
                         input int ad, input logic [7:0] wm);
        bus.ren = r; bus.wen = w; bus.alloc = a; bus.inv = iv; bus.flush = f;
        bus.din = d; bus.addr = 4'(ad);
`ifdef CAM_TERNARY_EN
        bus.wmask = wm;
`endif
    endtask

    task automatic op(input string ctx, input bit r, w, a, iv, f,
                      input logic [7:0] d, input int ad, input logic [7:0] wm);
        drive(r, w, a, iv, f, d, ad, wm);
        model_apply(r, w, a, iv, f, d, ad, wm);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx, input bit r, w);
        drive(r, w, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all(ctx);
    endtask

    initial begin
        bit r, w, a, iv, f;
        logic [7:0] d, wm;

        for (int i = 0; i < 16; i++) begin md[i] = 8'h00; mm[i] = 8'h00; end
        do_reset("reset", 1'b0, 1'b0);
        op("stale_search", 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);

        op("wr_a5_3",  0, 1, 0, 0, 0, 8'hA5, 3, 8'h00);
        op("wr_a5_9",  0, 1, 0, 0, 0, 8'hA5, 9, 8'h00);
        op("dup_srch", 1, 0, 0, 0, 0, 8'hA5, 0, 8'h00);
        chk("dup_dout_is_3", 32'(bus.dout), 32'd3);
        op("hold_1cyc", 0, 0, 0, 0, 0, 8'hA5, 0, 8'h00);
        op("inv_3",    0, 0, 0, 1, 0, 8'h00, 3, 8'h00);
        op("inv_3_again", 0, 0, 0, 1, 0, 8'h00, 3, 8'h00);
        op("srch_9",   1, 0, 0, 0, 0, 8'hA5, 0, 8'h00);
        chk("srch_dout_is_9", 32'(bus.dout), 32'd9);

        op("flush0", 0, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            op("alloc_fill", 0, 1, 1, 0, 0, 8'(8'h10 + i), 7, 8'h00);
            chk("alloc_wr_addr", 32'(bus.wr_addr), 32'(i));
        end
        chk("full_flag", 32'(bus.full), 32'd1);
        op("alloc_full", 0, 1, 1, 0, 0, 8'hEE, 2, 8'h00);
        chk("full_wr_err", 32'(bus.wr_err), 32'd1);
        op("err_pulse", 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        op("srch_15", 1, 0, 0, 0, 0, 8'h15, 0, 8'h00);

        op("ren_wen_same", 1, 1, 0, 0, 0, 8'h55, 0, 8'h00);
        op("wr_55_0", 0, 1, 0, 0, 0, 8'h55, 0, 8'h00);
        op("srch_55", 1, 0, 0, 0, 0, 8'h55, 0, 8'h00);

        op("flush_full", 0, 0, 0, 0, 1, 8'h00, 0, 8'h00);
        op("srch_after_flush", 1, 0, 0, 0, 0, 8'h12, 0, 8'h00);
        op("wr_77_5", 0, 1, 0, 0, 0, 8'h77, 5, 8'h00);
        op("flush_ren", 1, 0, 0, 0, 1, 8'h77, 0, 8'h00);

`ifdef CAM_TERNARY_EN
        op("tern_wr", 0, 1, 0, 0, 0, 8'hA0, 2, 8'h0F);
        op("tern_a7", 1, 0, 0, 0, 0, 8'hA7, 0, 8'h00);
        op("tern_b7", 1, 0, 0, 0, 0, 8'hB7, 0, 8'h00);
`endif

        op("pre_rst_wr", 0, 1, 1, 0, 0, 8'h33, 0, 8'h00);
        op("pre_rst_wr2", 0, 1, 0, 0, 0, 8'h33, 11, 8'h00);
        do_reset("rst_wins", 1'b1, 1'b1);
        op("post_rst_srch", 1, 0, 0, 0, 0, 8'h33, 0, 8'h00);

        for (int k = 0; k < 500; k++) begin
            f  = ($urandom_range(0, 99) < 4);
            r  = ($urandom_range(0, 99) < 35);
            w  = ($urandom_range(0, 99) < 50);
            a  = ($urandom_range(0, 1) == 1);
            iv = ($urandom_range(0, 99) < 30);
            d  = 8'($urandom_range(0, 11));
            wm = TERN ? 8'($urandom_range(0, 3)) : 8'h00;
            op("rand", r, w, a, iv, f, d, $urandom_range(0, 15), wm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_cam.md
# param_cam

Parametrised content-addressable memory, successor to the fixed 16x8 CAM used in the lab datapath. It adds per-entry valid bits and single-entry invalidate, whole-array flush, auto-allocating writes to the lowest free slot, and occupancy/full status. Searches return the lowest matching index plus a multi-hit flag. It sits beside the lookup pipeline as a registered one-cycle search engine.

## Interface
- DATA_W, 8, width of stored/search word
- DEPTH, 16, number of entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), entry index width (derived; do not override)
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ren  in  1  search strobe (din is the key)
- wen  in  1  write strobe
- alloc  in  1  with wen: write to lowest free entry, ignore addr
- inv  in  1  invalidate entry addr
- flush  in  1  invalidate all entries
- din  in  DATA_W  write data / search key
- addr  in  ADDR_W  explicit write/invalidate index
- wmask  in  DATA_W  don't-care mask, present only with CAM_TERNARY_EN
- dout  out  ADDR_W  lowest matching index (registered)
- hit  out  1  ≥1 valid entry matched
- multi_hit  out  1  ≥2 valid entries matched
- wr_addr  out  ADDR_W  index actually written last cycle
- wr_err  out  1  alloc write dropped because array full
- count  out  ADDR_W+1  number of valid entries
- full  out  1  count == DEPTH

## Operation
- One operation per cycle; priority flush > ren > wen > inv; lower-priority strobes in the same cycle are ignored entirely.
- Search: compare din against every entry; only entries with valid=1 can match. dout = lowest matching index, hit=1, multi_hit=1 if two or more matched. No match: dout=0, hit=0, multi_hit=0.
- Cycles without ren: dout, hit, multi_hit driven 0.
- Explicit write (wen, alloc=0): entry[addr]←din, valid[addr]←1; wr_addr=addr; count +1 only if entry was invalid.
- Alloc write (wen, alloc=1): target = lowest index with valid=0; write as above, wr_addr=target. If full: no state change, wr_err=1 for one cycle, wr_addr holds.
- inv: valid[addr]←0; count −1 only if entry was valid; invalid entry → no-op.
- flush: all valid←0, count←0; data contents left as-is.
- Duplicate keys permitted; lowest index wins.
- Reset: valid all 0, count=0, full=0, dout=0, hit=0, multi_hit=0, wr_addr=0, wr_err=0. Data array not reset; stale data never hits because valid=0.

## Timing
- Search latency 1 cycle: key at edge N, result valid after edge N, held for exactly one cycle.
- Search sees array state before edge N; write at N visible to search issued at N+1.
- count/full update at the same edge as the write/inv/flush.
- wr_err and wr_addr update at the edge consuming the write; wr_err is a one-cycle pulse.
- rst wins over all strobes in the same cycle; rst mid-sequence discards pending results.

## Configuration
- CAM_TERNARY_EN defined: wmask port exists; wmask stored per entry on every write; search ignores bit i where stored mask bit i=1. Flush/inv do not alter masks.
- Undefined: no wmask port, no mask storage, exact match on all DATA_W bits.

## Structure
- Package cam_pkg: op-priority encoding constants and a helper for ADDR_W derivation.
- Sub-module cam_prio_enc: parametrised DEPTH-bit lowest-set-bit encoder with any/multi outputs; instantiated twice (match vector → dout/hit/multi_hit, ~valid vector → alloc target/full).

## Test plan
- Reset, then ren with din=0x00 → hit=0, dout=0, count=0 (stale data never hits).
- Write 0xA5 at addr 3 and addr 9, ren din=0xA5 → dout=3, hit=1, multi_hit=1; inv addr 3, ren → dout=9, multi_hit=0.
- 16 alloc writes of 0x10..0x1F → wr_addr 0..15, count=16, full=1; 17th alloc → wr_err=1, count stays 16.
- ren+wen same cycle (write 0x55 addr 0, search 0x55) → write ignored, hit=0; next-cycle write then search → hit=1, dout=0.
- flush after filled array → count=0, full=0, any search hit=0; flush+ren same cycle → hit=0.
- CAM_TERNARY_EN: write 0xA0 mask 0x0F at addr 2, search 0xA7 → hit=1, dout=2; search 0xB7 → hit=0.
